// File: rtl/mm_bram_responder.sv
// mm_bram_responder: single-clock word array standing in for the Montgomery
// multiplier's external Block RAM. The core port (byte-addressed, byte write
// enables, read-first) always wins; a host port with a req/ack handshake
// preloads operands and unloads results when the core port is idle.
// Optional build macro: MM_BRAM_OUTREG_EN adds an output register on both
// read paths (read latency 2 instead of 1).
module mm_bram_responder #(
   parameter int DEPTH = 64
) (
   input  logic                     clock_i,
   input  logic                     reset_ni,
   // core (BRAM master) port
   input  logic                     BRAM_en_i,
   input  logic [3:0]               BRAM_we_i,
   input  logic [31:0]              BRAM_addr_i,
   input  logic [31:0]              BRAM_din_i,
   output logic [31:0]              BRAM_dout_o,
   // host port
   input  logic                     host_req_i,
   input  logic                     host_we_i,
   input  logic [$clog2(DEPTH)-1:0] host_addr_i,
   input  logic [31:0]              host_wdata_i,
   output logic                     host_ack_o,
   output logic [31:0]              host_rdata_o,
   output logic                     host_rvalid_o,
   output logic                     err_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   logic [31:0] mem_q [DEPTH];

   state_t      state_q;
   logic        host_ack_q;
   logic [31:0] core_rd_q;
   logic [31:0] host_rd_q;
   logic        host_pend_q;
   logic [31:0] host_rdata_q;
   logic        host_rvalid_q;
   logic        err_q;

   // Core address decode: low two bits only flag misalignment, upper bits
   // beyond the array make the access out of range.
   logic [AW-1:0] core_idx;
   logic          core_oor;
   logic          core_misaligned;
   logic          core_wr;
   logic          host_go;
   logic          err_d;

   assign core_idx        = BRAM_addr_i[AW+1:2];
   assign core_oor        = |BRAM_addr_i[31:AW+2];
   assign core_misaligned = |BRAM_addr_i[1:0];
   assign core_wr         = BRAM_en_i & ~core_oor & (|BRAM_we_i);

   // The host is served only on a cycle the core leaves idle, so the two
   // ports never touch the array on the same edge.
   assign host_go = (state_q == ST_IDLE) & host_req_i & ~BRAM_en_i;
   assign err_d   = err_q | (BRAM_en_i & (core_misaligned | core_oor));

   // Array writes: core byte lanes, or a full host word when granted.
   // NOTE: the array has no reset on purpose; contents survive reset and a
   // resettable array could not map onto block RAM.
   always_ff @(posedge clock_i) begin
      if (core_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (BRAM_we_i[b]) mem_q[core_idx][8*b +: 8] <= BRAM_din_i[8*b +: 8];
         end
      end else if (host_go && host_we_i) begin
         mem_q[host_addr_i] <= host_wdata_i;
      end
   end

   // Core read stage and sticky error flag; the read holds when en is low.
   // NOTE: non-blocking assignment here is what makes the read return the
   // pre-write word when the same edge also writes it (read-first).
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         core_rd_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (BRAM_en_i) core_rd_q <= core_oor ? 32'h0 : mem_q[core_idx];
         err_q <= err_d;
      end
   end

   // Host arbitration FSM: one-cycle GRANT with a registered ack pulse.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         host_ack_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (host_go) begin
                  state_q    <= ST_GRANT;
                  host_ack_q <= 1'b1;
               end else begin
                  host_ack_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               host_ack_q <= 1'b0;
            end
         endcase
      end
   end

   // Host read launch: capture the word on the grant edge.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         host_rd_q   <= '0;
         host_pend_q <= 1'b0;
      end else begin
         host_pend_q <= host_go & ~host_we_i;
         if (host_go && !host_we_i) host_rd_q <= mem_q[host_addr_i];
      end
   end

`ifdef MM_BRAM_OUTREG_EN
   logic        core_vld_q;
   logic [31:0] core_dout_q;
   logic [31:0] host_s2_q;
   logic        host_s2_vld_q;

   // Output register stage: loads only when the stage before holds fresh data.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         core_vld_q    <= 1'b0;
         core_dout_q   <= '0;
         host_s2_q     <= '0;
         host_s2_vld_q <= 1'b0;
      end else begin
         core_vld_q    <= BRAM_en_i;
         if (core_vld_q) core_dout_q <= core_rd_q;
         host_s2_vld_q <= host_pend_q;
         if (host_pend_q) host_s2_q <= host_rd_q;
      end
   end

   // Host read return, one stage behind the output register.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         host_rvalid_q <= host_s2_vld_q;
         if (host_s2_vld_q) host_rdata_q <= host_s2_q;
      end
   end

   assign BRAM_dout_o = core_dout_q;
`else
   // Host read return: rdata holds its last value, rvalid pulses once.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         host_rvalid_q <= host_pend_q;
         if (host_pend_q) host_rdata_q <= host_rd_q;
      end
   end

   assign BRAM_dout_o = core_rd_q;
`endif

   assign host_ack_o    = host_ack_q;
   assign host_rdata_o  = host_rdata_q;
   assign host_rvalid_o = host_rvalid_q;
   assign err_o         = err_q;

endmodule

// File: doc/mm_bram_responder.md
# mm_bram_responder

Single-clock BRAM responder serving the Montgomery multiplier's BRAM master port (32-bit data, byte address, 4-bit byte write enable, enable) from an internal word array. It also exposes a host port, with a request/acknowledge handshake, that preloads operands and unloads results. The core port always has priority. The block replaces the external Block RAM in simulation and in standalone builds.

## Interface
- DEPTH, 64: number of 32-bit words; must be a power of two, ≥ 4.
- AW, localparam $clog2(DEPTH): word-index width.
- clock_i  in  1  single clock; all logic on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- BRAM_en_i  in  1  core access enable.
- BRAM_we_i  in  4  core byte write enables; bit k writes byte k.
- BRAM_addr_i  in  32  core byte address; word index = addr[AW+1:2].
- BRAM_din_i  in  32  core write data.
- BRAM_dout_o  out  32  core read data.
- host_req_i  in  1  host access request; held until acknowledged.
- host_we_i  in  1  1 = write the full word, 0 = read.
- host_addr_i  in  AW  host word index.
- host_wdata_i  in  32  host write data.
- host_ack_o  out  1  one-cycle grant pulse.
- host_rdata_o  out  32  host read data.
- host_rvalid_o  out  1  one-cycle pulse qualifying host_rdata_o.
- err_o  out  1  sticky error flag for core accesses.

## Operation
- Array contents are not reset; they are retained across reset.
- Core port, on a cycle with BRAM_en_i=1:
  - Write the bytes selected by BRAM_we_i.
  - Read the addressed word, read-first: dout returns the pre-write contents.
  - BRAM_we_i=0 is a pure read.
- Core address rules:
  - addr[1:0]≠0: the bits are ignored for word selection and err_o is set.
  - addr[31:AW+2]≠0 (out of range): write suppressed, read returns 0, err_o set.
- BRAM_dout_o holds its last value on cycles with BRAM_en_i=0.
- err_o clears only on reset.
- Host arbitration is a two-state FSM:
  - IDLE → GRANT when host_req_i=1 and BRAM_en_i=0.
  - In GRANT: host_ack_o=1; write performed, or read launched. Return to IDLE the next cycle.
  - BRAM_en_i=1 in IDLE blocks the grant. The host waits indefinitely; there is no fairness counter.
  - The host must drop or change host_req_i in the cycle after ack. Requests still held are re-granted, at most one grant per 2 cycles.
- Host writes are full-word only.
- Core/host same-address hazards cannot occur within a cycle: the core port has exclusive priority.
- Reset asserted mid-operation: the FSM returns to IDLE and any in-flight host read is dropped (no rvalid).

## Timing
- Reset values: BRAM_dout_o=0, host_ack_o=0, host_rdata_o=0, host_rvalid_o=0, err_o=0, FSM=IDLE.
- Core read latency L:
  - L=1 by default: data on BRAM_dout_o in the cycle after BRAM_en_i.
  - L=2 with the output register enabled.
- Host read: host_rvalid_o pulses L cycles after host_ack_o.
- Host write: visible to a core read issued on the cycle after host_ack_o.
- err_o asserts in the cycle after the offending access.
- Core back-to-back accesses: one per cycle, no bubbles.

## Configuration
- MM_BRAM_OUTREG_EN defined:
  - Adds an output pipeline register on both read paths. L=2.
  - The register loads only when the previous stage holds fresh read data.
  - BRAM_dout_o still holds between accesses.
- Undefined: L=1, with no output register stage.

## Test plan
- Host write 0x0001ABCD to word 3, then core read, BRAM_addr_i=0x0C → BRAM_dout_o=0x0001ABCD one cycle after en (two with MM_BRAM_OUTREG_EN).
- Word 5 holds 0. Core write BRAM_we_i=4'b0001, din=0xFFFFFFFF at 0x14, then read → 0x000000FF. Same-cycle read of a written word returns the old value.
- host_req_i held while BRAM_en_i=1 for 5 cycles → host_ack_o stays 0. host_ack_o pulses the first cycle en is low; a host read of word 3 then gives host_rvalid_o with 0x0001ABCD L cycles later.
- Core access at 0x0D → err_o=1 next cycle and word 3 is accessed. Access at 0x100 with DEPTH=64 and we=4'hF → no array change, dout=0, err_o stays 1.
- Assert reset_ni=0 between host_ack_o and host_rvalid_o → no rvalid. All outputs 0. Word 3 still reads 0x0001ABCD after reset.
- 16 consecutive core reads of words 0–15 with en held high → 16 consecutive valid dout words in address order, no gaps.
